fwd_layer_mac: RTL and testbench

- Parametrised, serial-input forward-propagation layer for the DQN datapath, in Q(DW-FRAC).FRAC fixed point (default Q6.10).
- Accepts N_IN activations one per beat on a valid/ready stream. Accumulates each against a per-beat column of N_OUT weights, adds per-neuron bias, applies saturation and selectable activation.
- Presents N_OUT results in parallel behind a valid/ready output.
- Sits between the weight/bias stores and the next layer or the Q-value selector. One instance per network layer, replacing hand-written per-layer neuron arrays.

---
 rtl/fwd_layer_mac.sv | 207 ++++++++++++++++++++
 tb/tb_fwd_layer_mac.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_layer_mac.sv
// fwd_layer_mac: serial-input forward layer for the DQN datapath.
// Takes N_IN activation beats, multiplies each beat by a column of N_OUT
// weights and accumulates. Bias is then added and the result is shifted to
// Q(DW-FRAC).FRAC, saturated and passed through identity or ReLU. The N_OUT
// results are presented in parallel behind a valid/ready handshake.
// Optional build macro: FWD_LAYER_MAC_LEAKY_EN (ReLU becomes leaky, slope 1/8).
module fwd_layer_mac #(
    parameter int DW    = 16,
    parameter int FRAC  = 10,
    parameter int N_IN  = 9,
    parameter int N_OUT = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        clr,
    input  logic                        act_sel,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DW-1:0]               in_data,
    input  logic [N_OUT*DW-1:0]         w_col,
    input  logic [N_OUT*DW-1:0]         bias,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N_OUT*DW-1:0]         out_data,
    output logic                        busy,
    output logic [$clog2(N_IN+1)-1:0]   beat_cnt
);
    localparam int CW    = $clog2(N_IN + 1);
    localparam int ACC_W = 2 * DW + $clog2(N_IN);

    localparam logic signed [ACC_W-1:0] ONE_A   = {{(ACC_W-1){1'b0}}, 1'b1};
    localparam logic signed [ACC_W-1:0] SAT_MAX = (ONE_A <<< (DW - 1)) - ONE_A;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -(ONE_A <<< (DW - 1));
    localparam logic signed [DW-1:0]    SAT_HI  = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0]    SAT_LO  = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ACC  = 3'd1,
        S_BIAS = 3'd2,
        S_ACT  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q [N_OUT];
    logic signed [ACC_W-1:0] acc_d [N_OUT];
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    act_q, act_d;
    logic                    valid_q, valid_d;
    logic [N_OUT*DW-1:0]     out_q, out_d;
    logic                    in_ready_q, in_ready_d;
    logic                    busy_q, busy_d;

    // Full-precision signed product, sign-extended to the accumulator width.
    function automatic logic signed [ACC_W-1:0] mul_ext(input logic signed [DW-1:0] a,
                                                        input logic signed [DW-1:0] b);
        logic signed [2*DW-1:0] p;
        p = a * b;
        return ACC_W'(p);
    endfunction

    // Bias moved onto the product scale (2*FRAC fractional bits).
    function automatic logic signed [ACC_W-1:0] bias_ext(input logic signed [DW-1:0] b);
        logic signed [ACC_W-1:0] e;
        e = ACC_W'(b);
        return e <<< FRAC;
    endfunction

    // Rescale (floor), saturate to DW bits, then apply the selected activation.
    function automatic logic [DW-1:0] activate(input logic signed [ACC_W-1:0] a,
                                               input logic relu);
        logic signed [ACC_W-1:0] r;
        logic signed [DW-1:0]    s;
        r = a >>> FRAC;
        if (r > SAT_MAX) begin
            s = SAT_HI;
        end else if (r < SAT_MIN) begin
            s = SAT_LO;
        end else begin
            s = r[DW-1:0];
        end
        if (relu && s[DW-1]) begin
`ifdef FWD_LAYER_MAC_LEAKY_EN
            s = s >>> 3;
`else
            s = '0;
`endif
        end else begin
            s = s;
        end
        return s;
    endfunction

    // Next-state and datapath update; clr has priority over every state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        act_d   = act_q;
        valid_d = valid_q;
        out_d   = out_q;
        for (int j = 0; j < N_OUT; j++) begin
            acc_d[j] = acc_q[j];
        end
        if (clr) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            valid_d = 1'b0;
            out_d   = '0;
            for (int j = 0; j < N_OUT; j++) begin
                acc_d[j] = '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_ACC;
                        cnt_d   = '0;
                        act_d   = act_sel;
                        for (int j = 0; j < N_OUT; j++) begin
                            acc_d[j] = '0;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ACC: begin
                    if (in_valid) begin
                        for (int j = 0; j < N_OUT; j++) begin
                            acc_d[j] = acc_q[j] + mul_ext(in_data, w_col[j*DW +: DW]);
                        end
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == CW'(N_IN - 1)) begin
                            state_d = S_BIAS;
                        end else begin
                            state_d = S_ACC;
                        end
                    end else begin
                        state_d = S_ACC;
                    end
                end
                S_BIAS: begin
                    for (int j = 0; j < N_OUT; j++) begin
                        acc_d[j] = acc_q[j] + bias_ext(bias[j*DW +: DW]);
                    end
                    state_d = S_ACT;
                end
                S_ACT: begin
                    for (int j = 0; j < N_OUT; j++) begin
                        out_d[j*DW +: DW] = activate(acc_q[j], act_q);
                    end
                    valid_d = 1'b1;
                    state_d = S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        valid_d = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
        in_ready_d = (state_d == S_ACC);
        busy_d     = (state_d != S_IDLE);
    end

    // State, accumulator and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            act_q      <= 1'b0;
            valid_q    <= 1'b0;
            out_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            for (int j = 0; j < N_OUT; j++) begin
                acc_q[j] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            act_q      <= act_d;
            valid_q    <= valid_d;
            out_q      <= out_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            for (int j = 0; j < N_OUT; j++) begin
                acc_q[j] <= acc_d[j];
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign out_data  = out_q;
    assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_fwd_layer_mac.sv
// Self-checking bench for fwd_layer_mac (N_IN=3, N_OUT=2, Q6.10).
module tb_fwd_layer_mac;
    localparam int DW = 16, FRAC = 10, N_IN = 3, N_OUT = 2, CW = 2;

    logic clk = 1'b0;
    logic rst, start, clr, act_sel, in_valid, out_ready;
    logic [DW-1:0]       in_data;
    logic [N_OUT*DW-1:0] w_col, bias;
    logic                in_ready, out_valid, busy;
    logic [N_OUT*DW-1:0] out_data;
    logic [CW-1:0]       beat_cnt;

    int checks = 0;
    int failures = 0;

    logic [15:0] in_v [N_IN];
    logic [15:0] w_v  [N_IN][N_OUT];
    logic [15:0] b_v  [N_OUT];
    logic        act_v;

    fwd_layer_mac #(.DW(DW), .FRAC(FRAC), .N_IN(N_IN), .N_OUT(N_OUT)) dut (
        .clk(clk), .rst(rst), .start(start), .clr(clr), .act_sel(act_sel),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .w_col(w_col), .bias(bias), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: real-valued dot product in integer form, floor rescale, clamp, activation.
    function automatic logic [15:0] model(input int j);
        longint acc;
        longint r;
        acc = 0;
        for (int i = 0; i < N_IN; i++) begin
            acc = acc + longint'($signed(in_v[i])) * longint'($signed(w_v[i][j]));
        end
        acc = acc + longint'($signed(b_v[j])) * 1024;
        r = acc >>> FRAC;
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
        if (act_v && r < 0) begin
`ifdef FWD_LAYER_MAC_LEAKY_EN
            r = r >>> 3;
`else
            r = 0;
`endif
        end
        return r[15:0];
    endfunction

    task automatic set_basic();
        in_v[0] = 16'h0400; in_v[1] = 16'h0800; in_v[2] = 16'hFC00;
        for (int i = 0; i < N_IN; i++) begin
            w_v[i][0] = 16'h0200;
            w_v[i][1] = 16'hFC00;
        end
        b_v[0] = 16'h0100; b_v[1] = 16'h0000;
        act_v = 1'b1;
        bias = {b_v[1], b_v[0]};
    endtask

    task automatic feed_beat(input int i);
        in_valid = 1'b1;
        in_data  = in_v[i];
        for (int j = 0; j < N_OUT; j++) w_col[j*DW +: DW] = w_v[i][j];
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        w_col    = 32'($urandom);
    endtask

    task automatic pulse_start();
        act_sel = act_v;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        act_sel = 1'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Full inference with random idle gaps between beats; returns cycles to out_valid.
    task automatic infer(input int gap_max, output int lat);
        pulse_start();
        for (int i = 0; i < N_IN; i++) begin
            int g;
            g = $urandom_range(gap_max, 0);
            for (int k = 0; k < g; k++) @(negedge clk);
            feed_beat(i);
        end
        wait_valid(lat);
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (beat_cnt !== 2'd0) begin failures++; $display("FAIL reset_beat_cnt: got %0d want 0", beat_cnt); end
        checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_result(input string name, input int lat);
        logic [15:0] e0, e1;
        e0 = model(0);
        e1 = model(1);
        checks++; if (lat !== 2) begin failures++; $display("FAIL %s_latency: got %0d want 2", name, lat); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL %s_out_valid: got %b want 1", name, out_valid); end
        checks++; if (out_data[15:0] !== e0) begin failures++; $display("FAIL %s_n0: got %h want %h", name, out_data[15:0], e0); end
        checks++; if (out_data[31:16] !== e1) begin failures++; $display("FAIL %s_n1: got %h want %h", name, out_data[31:16], e1); end
    endtask

    task automatic test_basic();
        int lat;
        set_basic();
        infer(0, lat);
        check_result("basic", lat);
        checks++; if (out_data[15:0] !== 16'h0500) begin failures++; $display("FAIL basic_n0_const: got %h want 0500", out_data[15:0]); end
        accept();
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL basic_idle: got busy=%b valid=%b want 0 0", busy, out_valid); end
    endtask

    task automatic test_saturation();
        int lat;
        for (int i = 0; i < N_IN; i++) begin
            in_v[i] = 16'h7C00; w_v[i][0] = 16'h7C00; w_v[i][1] = 16'h8400;
        end
        b_v[0] = 16'h0; b_v[1] = 16'h0; act_v = 1'b0;
        bias = 32'h0;
        infer(1, lat);
        check_result("sat", lat);
        checks++; if (out_data !== 32'h8000_7FFF) begin failures++; $display("FAIL sat_const: got %h want 80007fff", out_data); end
        accept();
    endtask

    task automatic test_stall();
        int lat, bi;
        logic [31:0] snap;
        logic pat [6];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        set_basic();
        pulse_start();
        bi = 0;
        for (int k = 0; k < 6; k++) begin
            if (pat[k]) begin
                feed_beat(bi);
                bi++;
            end else begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            checks++; if (beat_cnt !== 2'(bi)) begin failures++; $display("FAIL stall_beat_cnt_%0d: got %0d want %0d", k, beat_cnt, bi); end
            checks++; if (in_ready !== (bi < N_IN)) begin failures++; $display("FAIL stall_in_ready_%0d: got %b want %b", k, in_ready, bi < N_IN); end
        end
        wait_valid(lat);
        check_result("stall", lat);
        snap = out_data;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || out_data !== snap) begin failures++; $display("FAIL stall_hold_%0d: got valid=%b data=%h want 1 %h", k, out_valid, out_data, snap); end
        end
        accept();
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL stall_idle: got busy=%b valid=%b want 0 0", busy, out_valid); end
        checks++; if (out_data !== snap) begin failures++; $display("FAIL stall_retain: got %h want %h", out_data, snap); end
    endtask

    task automatic test_ignored_start();
        int lat;
        for (int i = 0; i < N_IN; i++) begin
            in_v[i] = 16'($urandom_range(4095, 0) - 2048);
            w_v[i][0] = 16'($urandom_range(4095, 0) - 2048);
            w_v[i][1] = 16'($urandom_range(4095, 0) - 2048);
        end
        b_v[0] = 16'h0C00; b_v[1] = 16'hF400; act_v = 1'b0;
        bias = {b_v[1], b_v[0]};
        pulse_start();
        feed_beat(0);
        start = 1'b1; act_sel = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (beat_cnt !== 2'd1 || busy !== 1'b1) begin failures++; $display("FAIL ign_acc: got cnt=%0d busy=%b want 1 1", beat_cnt, busy); end
        feed_beat(1);
        feed_beat(2);
        wait_valid(lat);
        check_result("ign", lat);
        out_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (busy !== 1'b0 || beat_cnt !== 2'd3) begin failures++; $display("FAIL ign_done_%0d: got busy=%b cnt=%0d want 0 3", k, busy, beat_cnt); end
            @(negedge clk);
        end
    endtask

    task automatic test_abort();
        int lat;
        set_basic();
        pulse_start();
        feed_beat(0);
        feed_beat(1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++; if (busy !== 1'b0 || beat_cnt !== 2'd0) begin failures++; $display("FAIL abort_state: got busy=%b cnt=%0d want 0 0", busy, beat_cnt); end
        checks++; if (out_data !== 32'h0 || out_valid !== 1'b0) begin failures++; $display("FAIL abort_out: got data=%h valid=%b want 0 0", out_data, out_valid); end
        infer(0, lat);
        check_result("abort_rerun", lat);
        accept();
    endtask

    task automatic test_async_reset();
        int lat;
        set_basic();
        pulse_start();
        feed_beat(0);
        #1 rst = 1'b0;
        #1;
        checks++; if (out_data !== 32'h0 || out_valid !== 1'b0) begin failures++; $display("FAIL arst_out: got data=%h valid=%b want 0 0", out_data, out_valid); end
        checks++; if (in_ready !== 1'b0 || busy !== 1'b0 || beat_cnt !== 2'd0) begin failures++; $display("FAIL arst_ctl: got rdy=%b busy=%b cnt=%0d want 0 0 0", in_ready, busy, beat_cnt); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        infer(0, lat);
        check_result("arst_rerun", lat);
        accept();
    endtask

    task automatic test_random();
        int lat;
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < N_IN; i++) begin
                for (int j = 0; j < N_OUT; j++) begin
                    w_v[i][j] = (it % 2 == 0) ? 16'($urandom) : 16'($urandom_range(4095, 0) - 2048);
                end
                in_v[i] = (it % 2 == 0) ? 16'($urandom) : 16'($urandom_range(4095, 0) - 2048);
            end
            for (int j = 0; j < N_OUT; j++) b_v[j] = 16'($urandom);
            act_v = 1'($urandom);
            bias = {b_v[1], b_v[0]};
            infer(2, lat);
            check_result("rand", lat);
            for (int k = 0; k < int'($urandom_range(3, 0)); k++) @(negedge clk);
            accept();
        end
    endtask

    initial begin
        start = 1'b0; clr = 1'b0; act_sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; w_col = '0; bias = '0; act_v = 1'b0;
        test_reset();
        test_basic();
        test_saturation();
        test_stall();
        test_ignored_start();
        test_abort();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
